// File: rtl/minn_pkg.sv
// Shared types, default widths and sizing helpers for the Minn timing-sync controller.
package minn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_WARMUP,
    ST_SEARCH,
    ST_TRACK,
    ST_HOLDOFF
  } sync_state_t;

  localparam int MINN_METRIC_WIDTH = 24;
  localparam int MINN_ENERGY_WIDTH = 24;
  localparam int MINN_THRESH_WIDTH = 8;
  localparam int MINN_THRESH_FRAC  = 8;

  // Scaled-metric and scaled-energy product widths; the compare runs at the larger.
  localparam int MINN_LHS_WIDTH  = MINN_METRIC_WIDTH + MINN_THRESH_FRAC;
  localparam int MINN_RHS_WIDTH  = MINN_ENERGY_WIDTH + MINN_THRESH_WIDTH;
  localparam int MINN_PROD_WIDTH = (MINN_LHS_WIDTH > MINN_RHS_WIDTH) ? MINN_LHS_WIDTH : MINN_RHS_WIDTH;

  function automatic int prod_width(input int mw, input int ew, input int tw, input int tf);
    return ((mw + tf) > (ew + tw)) ? (mw + tf) : (ew + tw);
  endfunction

  // Bits needed to hold a count from 0 up to n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/minn_threshold_cmp.sv
// Full-precision strict compare: metric * 2^THRESH_FRAC > energy * thresh.
module minn_threshold_cmp
  import minn_pkg::*;
#(
  parameter int METRIC_WIDTH = MINN_METRIC_WIDTH,
  parameter int ENERGY_WIDTH = MINN_ENERGY_WIDTH,
  parameter int THRESH_WIDTH = MINN_THRESH_WIDTH,
  parameter int THRESH_FRAC  = MINN_THRESH_FRAC,
  parameter int PROD_WIDTH   = MINN_PROD_WIDTH
) (
  input  logic [METRIC_WIDTH-1:0] metric,
  input  logic [ENERGY_WIDTH-1:0] energy,
  input  logic [THRESH_WIDTH-1:0] thresh,
  output logic                    pass
);

  logic [PROD_WIDTH-1:0] lhs;
  logic [PROD_WIDTH-1:0] rhs;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    lhs = '0;
    lhs[METRIC_WIDTH+THRESH_FRAC-1:THRESH_FRAC] = metric;
    rhs  = PROD_WIDTH'(energy) * PROD_WIDTH'(thresh);
    pass = lhs > rhs;
  end

endmodule

// File: rtl/minn_sync_controller.sv
// Minn timing-sync control FSM: flush/warm-up of the running sums, threshold search,
// peak tracking over a confirmation window, detect strobe and optional hold-off re-arm.
module minn_sync_controller
  import minn_pkg::*;
#(
  parameter int METRIC_WIDTH = MINN_METRIC_WIDTH,
  parameter int ENERGY_WIDTH = MINN_ENERGY_WIDTH,
  parameter int THRESH_WIDTH = MINN_THRESH_WIDTH,
  parameter int THRESH_FRAC  = MINN_THRESH_FRAC,
  parameter int IDX_WIDTH    = 16,
  parameter int PEAK_WINDOW  = 16,
  parameter int HOLDOFF      = 64,
  parameter int TIMEOUT      = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    cfg_continuous,
  input  logic [THRESH_WIDTH-1:0] cfg_thresh,
  input  logic                    sums_valid,
  input  logic                    in_valid,
  input  logic [METRIC_WIDTH-1:0] metric_in,
  input  logic [ENERGY_WIDTH-1:0] energy_in,
  output logic                    sum_clear,
  output logic                    busy,
  output logic                    detect,
  output logic [IDX_WIDTH-1:0]    peak_idx,
  output logic [METRIC_WIDTH-1:0] peak_metric,
  output logic                    timeout
);

  localparam int PROD_WIDTH = prod_width(METRIC_WIDTH, ENERGY_WIDTH, THRESH_WIDTH, THRESH_FRAC);
  localparam int GAP_W      = cnt_width(PEAK_WINDOW);
  localparam int TCNT_W     = cnt_width(TIMEOUT);
  localparam int HCNT_W     = cnt_width(HOLDOFF);

  sync_state_t             state;
  logic [IDX_WIDTH-1:0]    idx;
  logic [IDX_WIDTH-1:0]    samp_idx;
  logic [IDX_WIDTH-1:0]    cand_idx;
  logic [METRIC_WIDTH-1:0] cand_metric;
  logic [GAP_W-1:0]        gap;
  logic [GAP_W-1:0]        gap_inc;
  logic [TCNT_W-1:0]       tcnt;
  logic [TCNT_W-1:0]       tcnt_inc;
  logic [HCNT_W-1:0]       hcnt;
  logic [HCNT_W-1:0]       hcnt_inc;
  logic                    pass;
  logic                    search_sample;

  minn_threshold_cmp #(
    .METRIC_WIDTH (METRIC_WIDTH),
    .ENERGY_WIDTH (ENERGY_WIDTH),
    .THRESH_WIDTH (THRESH_WIDTH),
    .THRESH_FRAC  (THRESH_FRAC),
    .PROD_WIDTH   (PROD_WIDTH)
  ) u_cmp (
    .metric (metric_in),
    .energy (energy_in),
    .thresh (cfg_thresh),
    .pass   (pass)
  );

  // The first full sample in WARMUP is index 0 and opens a fresh timeout count.
  always_comb begin
    samp_idx      = (state == ST_WARMUP) ? '0 : idx;
    tcnt_inc      = (state == ST_WARMUP) ? TCNT_W'(1) : tcnt + 1'b1;
    gap_inc       = gap + 1'b1;
    hcnt_inc      = hcnt + 1'b1;
    search_sample = in_valid & ((state == ST_SEARCH) | ((state == ST_WARMUP) & sums_valid));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      cand_idx    <= '0;
      cand_metric <= '0;
      gap         <= '0;
      tcnt        <= '0;
      hcnt        <= '0;
      sum_clear   <= 1'b0;
      busy        <= 1'b0;
      detect      <= 1'b0;
      timeout     <= 1'b0;
      peak_idx    <= '0;
      peak_metric <= '0;
    end else begin
      sum_clear <= 1'b0;
      detect    <= 1'b0;
      timeout   <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (arm) begin
              state     <= ST_FLUSH;
              sum_clear <= 1'b1;
              busy      <= 1'b1;
            end
          end
          ST_FLUSH: state <= ST_WARMUP;
          ST_WARMUP, ST_SEARCH: begin
            if (search_sample) begin
              idx <= samp_idx + 1'b1;
              if (pass) begin
                cand_idx    <= samp_idx;
                cand_metric <= metric_in;
                gap         <= '0;
                state       <= ST_TRACK;
              end else begin
                tcnt <= tcnt_inc;
                if (TIMEOUT != 0 && tcnt_inc == TCNT_W'(TIMEOUT)) begin
                  timeout <= 1'b1;
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
                end else begin
                  state <= ST_SEARCH;
                end
              end
            end
          end
          ST_TRACK: begin
            if (in_valid) begin
              idx <= idx + 1'b1;
              if (metric_in > cand_metric) begin
                cand_idx    <= idx;
                cand_metric <= metric_in;
                gap         <= '0;
              end else begin
                gap <= gap_inc;
                if (gap_inc == GAP_W'(PEAK_WINDOW)) begin
                  detect      <= 1'b1;
                  peak_idx    <= cand_idx;
                  peak_metric <= cand_metric;
                  if (!cfg_continuous) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                  end else if (HOLDOFF == 0) begin
                    state <= ST_SEARCH;
                    tcnt  <= '0;
                  end else begin
                    state <= ST_HOLDOFF;
                    hcnt  <= '0;
                  end
                end
              end
            end
          end
          ST_HOLDOFF: begin
            if (in_valid) begin
              idx  <= idx + 1'b1;
              hcnt <= hcnt_inc;
              if (hcnt_inc == HCNT_W'(HOLDOFF)) begin
                state <= ST_SEARCH;
                tcnt  <= '0;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
